rd_scoreboard: RTL and testbench
================================

Name: rd_scoreboard

Overview:
- Parametrised, synthesizable in-order read scoreboard for cache verification.
- Benches and on-FPGA self-check harnesses use it to record the expected data for each CPU read at issue time and to check the cache's read data on completion.
- Generalises the bench's ad-hoc queue check: configurable width and depth, a byte-lane compare mask, saturating statistics, first-mismatch capture, overflow/underflow detection and a completion-timeout watchdog.

Parameters:
- ADDR_W, 20: address width.
- DATA_W, 32: data width; must be a multiple of 8.
- DEPTH, 8: maximum outstanding reads; power of two, ≥2.
- CNT_W, 16: width of the statistic counters.
- TIMEOUT_CYC, 64: watchdog limit in cycles; 0 disables the watchdog.

Ports:
- clk, in, 1: clock; all logic on the rising edge.
- rst, in, 1: synchronous, active-high reset.
- issue_valid, in, 1: a read is issued this cycle (bench drives rw==0 && !stopped).
- issue_addr, in, ADDR_W: address of the issued read.
- issue_exp, in, DATA_W: expected data, taken from the shadow RAM.
- issue_mask, in, DATA_W/8: byte lanes to compare; 1 = compare.
- cmp_valid, in, 1: a read completes this cycle (cache ready).
- cmp_data, in, DATA_W: data returned by the cache.
- outstanding, out, $clog2(DEPTH)+1: current number of queued entries.
- full, out, 1: outstanding == DEPTH.
- empty, out, 1: outstanding == 0.
- mismatch, out, 1: one-cycle pulse reporting a failed compare.
- cmp_count, out, CNT_W: completed compares, saturating.
- err_count, out, CNT_W: failed compares, saturating.
- first_err_valid, out, 1: sticky; the first-error capture registers are loaded.
- first_err_addr, out, ADDR_W: address of the first failing read.
- first_err_exp, out, DATA_W: expected data of the first failing read.
- first_err_act, out, DATA_W: returned data of the first failing read.
- overflow, out, 1: sticky; an issue arrived while full with no pop.
- underflow, out, 1: sticky; a completion arrived while empty.
- timeout, out, 1: sticky; the watchdog expired.

Behaviour:
- Reset:
  - Queue is emptied: outstanding=0, empty=1, full=0.
  - All counters, sticky flags, mismatch and first_err_* registers are cleared to 0.
  - Reset applied mid-operation discards every queued entry.
- Storage: circular FIFO of {addr, exp, mask}. Write pointer advances on push, read pointer on pop; both wrap modulo DEPTH.
- Push: issue_valid && (!full || cmp_valid). Entry is written at the clock edge.
- Pop: cmp_valid && !empty. Compares against the head entry as it stood before this edge.
- An entry pushed in cycle N is never the compare target in cycle N. A completion in the same cycle refers to an older read.
- Simultaneous push and pop:
  - Allowed when full: outstanding stays DEPTH and no overflow is flagged.
  - Allowed when non-empty: outstanding is unchanged.
- Overflow: issue_valid && full && !cmp_valid. Entry is dropped, overflow set, queue untouched.
- Underflow: cmp_valid && empty, including when issue_valid is high the same cycle. No compare, no pop, underflow set; the concurrent push still proceeds.
- Compare:
  - fail = OR over lanes i of mask[i] && (cmp_data[8i+7:8i] != head.exp[8i+7:8i]).
  - A mask of all zeros always passes.
- Latency: mismatch and the counter updates appear on the edge that performs the pop, i.e. one cycle after cmp_valid is sampled. mismatch is high for exactly one cycle per failure.
- Statistics:
  - cmp_count increments on every pop.
  - err_count increments on every failure.
  - Both hold at 2^CNT_W-1 once reached; no wrap.
- First error: on the first failure after reset, load first_err_addr/exp/act and set first_err_valid. Later failures do not modify these registers.
- Watchdog, when TIMEOUT_CYC>0:
  - The 0-based cycle counter clears when empty or on a pop, and otherwise increments, saturating at TIMEOUT_CYC.
  - timeout sets when the counter reaches TIMEOUT_CYC while entries are outstanding.
- Sticky flags clear only on rst.

Test Plan:
- Reset then 4 reads (addrs 0x00010..0x00013, exp 0xA0..0xA3, mask 4'hF) with completions returning matching data 2 cycles later → cmp_count=4, err_count=0, mismatch never high, empty=1.
- One read with exp=0xDEADBEEF and mask=4'b0001, completion returns 0xDEADBE00 → mismatch pulses once, err_count=1, first_err_addr/exp/act = issue addr/0xDEADBEEF/0xDEADBE00. A second error at another address leaves first_err_* unchanged.
- Same as above with mask=4'b1110 → no mismatch (lane 0 masked).
- DEPTH=8: issue 8 reads without completion → full=1. Issue a 9th alone → overflow=1, outstanding=8. Issue and complete in the same cycle → outstanding stays 8, FIFO order preserved across wrap, no further error.
- cmp_valid while empty, with issue_valid in the same cycle → underflow=1, cmp_count=0, outstanding=1.
- TIMEOUT_CYC=64: issue 1 read and never complete → timeout=1 after 64 cycles. Assert rst mid-stream → all outputs return to 0, empty=1.

Source files
------------

// File: rtl/rd_scoreboard_if.sv
// rd_scoreboard_if: issue and completion channels of the read scoreboard
interface rd_scoreboard_if #(
  parameter int ADDR_W = 20,
  parameter int DATA_W = 32
);
  logic                  issue_valid;
  logic [ADDR_W-1:0]     issue_addr;
  logic [DATA_W-1:0]     issue_exp;
  logic [DATA_W/8-1:0]   issue_mask;
  logic                  cmp_valid;
  logic [DATA_W-1:0]     cmp_data;
  modport master (output issue_valid, issue_addr, issue_exp, issue_mask, cmp_valid, cmp_data);
  modport slave  (input  issue_valid, issue_addr, issue_exp, issue_mask, cmp_valid, cmp_data);
endinterface

// File: rtl/rd_scoreboard.sv
// rd_scoreboard: in-order read scoreboard with masked compare, stats, first-error capture and watchdog
module rd_scoreboard #(
  parameter int ADDR_W      = 20,
  parameter int DATA_W      = 32,
  parameter int DEPTH       = 8,
  parameter int CNT_W       = 16,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  rd_scoreboard_if.slave           bus,
  output logic [$clog2(DEPTH):0]   outstanding,
  output logic                     full,
  output logic                     empty,
  output logic                     mismatch,
  output logic [CNT_W-1:0]         cmp_count,
  output logic [CNT_W-1:0]         err_count,
  output logic                     first_err_valid,
  output logic [ADDR_W-1:0]        first_err_addr,
  output logic [DATA_W-1:0]        first_err_exp,
  output logic [DATA_W-1:0]        first_err_act,
  output logic                     overflow,
  output logic                     underflow,
  output logic                     timeout
);
  localparam int NB = DATA_W / 8;
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  logic [ADDR_W-1:0] addr_q [DEPTH];
  logic [DATA_W-1:0] exp_q  [DEPTH];
  logic [NB-1:0]     mask_q [DEPTH];
  logic [PW-1:0]     wp, rp;
  logic [NB-1:0]     lane_bad;
  logic              push, pop, fail;
  assign full  = outstanding == CW'(DEPTH);
  assign empty = outstanding == '0;
  assign push  = bus.issue_valid && (!full || bus.cmp_valid);
  assign pop   = bus.cmp_valid && !empty;
  always_comb begin
    lane_bad = '0;
    for (int i = 0; i < NB; i++)
      lane_bad[i] = mask_q[rp][i] && (bus.cmp_data[8*i +: 8] != exp_q[rp][8*i +: 8]);
  end
  assign fail = pop && |lane_bad;
  always_ff @(posedge clk) begin
    if (push) begin
      addr_q[wp] <= bus.issue_addr;
      exp_q[wp]  <= bus.issue_exp;
      mask_q[wp] <= bus.issue_mask;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      wp              <= '0;
      rp              <= '0;
      outstanding     <= '0;
      mismatch        <= 1'b0;
      cmp_count       <= '0;
      err_count       <= '0;
      first_err_valid <= 1'b0;
      first_err_addr  <= '0;
      first_err_exp   <= '0;
      first_err_act   <= '0;
      overflow        <= 1'b0;
      underflow       <= 1'b0;
    end else begin
      if (push) wp <= wp + 1'b1;
      if (pop) rp <= rp + 1'b1;
      outstanding <= outstanding + CW'(push) - CW'(pop);
      mismatch    <= fail;
      if (pop && ~&cmp_count) cmp_count <= cmp_count + 1'b1;
      if (fail && ~&err_count) err_count <= err_count + 1'b1;
      if (fail && !first_err_valid) begin
        first_err_valid <= 1'b1;
        first_err_addr  <= addr_q[rp];
        first_err_exp   <= exp_q[rp];
        first_err_act   <= bus.cmp_data;
      end
      if (bus.issue_valid && full && !bus.cmp_valid) overflow <= 1'b1;
      if (bus.cmp_valid && empty) underflow <= 1'b1;
    end
  end
  // Watchdog counts cycles since the last pop while reads are outstanding
  if (TIMEOUT_CYC > 0) begin : g_wd
    localparam int WD_W = $clog2(TIMEOUT_CYC + 1);
    logic [WD_W-1:0] wd;
    always_ff @(posedge clk) begin
      if (rst || empty || pop) wd <= '0;
      else if (wd != WD_W'(TIMEOUT_CYC)) wd <= wd + 1'b1;
    end
    always_ff @(posedge clk) begin
      if (rst) timeout <= 1'b0;
      else if (wd == WD_W'(TIMEOUT_CYC) && !empty) timeout <= 1'b1;
    end
  end else begin : g_nowd
    assign timeout = 1'b0;
  end
endmodule

// File: tb/tb_rd_scoreboard.sv
// tb_rd_scoreboard: table-driven and directed checks of rd_scoreboard
module tb_rd_scoreboard;
  logic clk = 1'b0;
  logic rst;
  logic [3:0]  outstanding;
  logic        full, empty, mismatch, first_err_valid, overflow, underflow, timeout;
  logic [15:0] cmp_count, err_count;
  logic [19:0] first_err_addr;
  logic [31:0] first_err_exp, first_err_act;
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  rd_scoreboard_if #(.ADDR_W(20), .DATA_W(32)) bus();
  rd_scoreboard #(.ADDR_W(20), .DATA_W(32), .DEPTH(8), .CNT_W(16), .TIMEOUT_CYC(64)) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .outstanding(outstanding), .full(full), .empty(empty), .mismatch(mismatch),
    .cmp_count(cmp_count), .err_count(err_count), .first_err_valid(first_err_valid),
    .first_err_addr(first_err_addr), .first_err_exp(first_err_exp), .first_err_act(first_err_act),
    .overflow(overflow), .underflow(underflow), .timeout(timeout)
  );
  typedef struct {
    logic        iv;
    logic [19:0] a;
    logic [31:0] e;
    logic [3:0]  m;
    logic        cv;
    logic [31:0] d;
    int          eo;
    int          ec;
    int          ee;
    logic        emis;
  } vec_t;
  vec_t v[15];
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask
  task automatic step(input logic iv, input logic [19:0] a, input logic [31:0] e, input logic [3:0] m,
                      input logic cv, input logic [31:0] d);
    @(negedge clk);
    bus.issue_valid = iv;
    bus.issue_addr  = a;
    bus.issue_exp   = e;
    bus.issue_mask  = m;
    bus.cmp_valid   = cv;
    bus.cmp_data    = d;
    @(posedge clk);
    #1;
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, '0, '0, '0, 1'b0, '0);
  endtask
  task automatic do_reset;
    @(negedge clk);
    rst = 1'b1;
    bus.issue_valid = 1'b0;
    bus.cmp_valid   = 1'b0;
    @(posedge clk);
    #1;
    @(negedge clk);
    rst = 1'b0;
  endtask
  task automatic chk_clear(input string tag);
    chk({tag, " outstanding"}, 64'(outstanding), 0);
    chk({tag, " empty"}, 64'(empty), 1);
    chk({tag, " full"}, 64'(full), 0);
    chk({tag, " counts"}, {32'(cmp_count), 32'(err_count)}, 0);
    chk({tag, " flags"}, {mismatch, first_err_valid, overflow, underflow, timeout}, 0);
    chk({tag, " first_err"}, {first_err_addr, first_err_exp ^ first_err_act}, 0);
    chk({tag, " first_err_exp"}, 64'(first_err_exp), 0);
  endtask
  initial begin
    v[0]  = '{1'b1, 20'h00010, 32'h000000A0, 4'hF, 1'b0, 32'h0,        1, 0, 0, 1'b0};
    v[1]  = '{1'b1, 20'h00011, 32'h000000A1, 4'hF, 1'b0, 32'h0,        2, 0, 0, 1'b0};
    v[2]  = '{1'b1, 20'h00012, 32'h000000A2, 4'hF, 1'b1, 32'h000000A0, 2, 1, 0, 1'b0};
    v[3]  = '{1'b1, 20'h00013, 32'h000000A3, 4'hF, 1'b1, 32'h000000A1, 2, 2, 0, 1'b0};
    v[4]  = '{1'b0, 20'h0,     32'h0,        4'h0, 1'b1, 32'h000000A2, 1, 3, 0, 1'b0};
    v[5]  = '{1'b0, 20'h0,     32'h0,        4'h0, 1'b1, 32'h000000A3, 0, 4, 0, 1'b0};
    v[6]  = '{1'b1, 20'h00020, 32'hDEADBEEF, 4'h1, 1'b0, 32'h0,        1, 4, 0, 1'b0};
    v[7]  = '{1'b0, 20'h0,     32'h0,        4'h0, 1'b1, 32'hDEADBE00, 0, 5, 1, 1'b1};
    v[8]  = '{1'b0, 20'h0,     32'h0,        4'h0, 1'b0, 32'h0,        0, 5, 1, 1'b0};
    v[9]  = '{1'b1, 20'h00030, 32'hDEADBEEF, 4'hE, 1'b0, 32'h0,        1, 5, 1, 1'b0};
    v[10] = '{1'b0, 20'h0,     32'h0,        4'h0, 1'b1, 32'hDEADBE00, 0, 6, 1, 1'b0};
    v[11] = '{1'b1, 20'h00040, 32'h12345678, 4'hF, 1'b0, 32'h0,        1, 6, 1, 1'b0};
    v[12] = '{1'b0, 20'h0,     32'h0,        4'h0, 1'b1, 32'h12345600, 0, 7, 2, 1'b1};
    v[13] = '{1'b1, 20'h00050, 32'h00000000, 4'h0, 1'b0, 32'h0,        1, 7, 2, 1'b0};
    v[14] = '{1'b0, 20'h0,     32'h0,        4'h0, 1'b1, 32'hFFFFFFFF, 0, 8, 2, 1'b0};
    rst = 1'b1;
    bus.issue_valid = 1'b0; bus.issue_addr = '0; bus.issue_exp = '0; bus.issue_mask = '0;
    bus.cmp_valid = 1'b0; bus.cmp_data = '0;
    do_reset();
    #1;
    chk_clear("reset");
    for (int i = 0; i < 15; i++) begin
      step(v[i].iv, v[i].a, v[i].e, v[i].m, v[i].cv, v[i].d);
      chk($sformatf("vec%0d outstanding", i), 64'(outstanding), 64'(v[i].eo));
      chk($sformatf("vec%0d cmp_count", i), 64'(cmp_count), 64'(v[i].ec));
      chk($sformatf("vec%0d err_count", i), 64'(err_count), 64'(v[i].ee));
      chk($sformatf("vec%0d mismatch", i), 64'(mismatch), 64'(v[i].emis));
    end
    chk("first_err_valid", 64'(first_err_valid), 1);
    chk("first_err_addr", 64'(first_err_addr), 64'h20);
    chk("first_err_exp", 64'(first_err_exp), 64'hDEADBEEF);
    chk("first_err_act", 64'(first_err_act), 64'hDEADBE00);
    chk("no sticky after table", {overflow, underflow, timeout, empty}, 4'b0001);
    do_reset();
    for (int i = 0; i < 8; i++) step(1'b1, 20'h100 + 20'(i), 32'hB0 + 32'(i), 4'hF, 1'b0, '0);
    chk("fill full", {full, 4'(outstanding)}, {1'b1, 4'd8});
    for (int k = 0; k < 8; k++) begin
      step(1'b1, 20'h108 + 20'(k), 32'hB8 + 32'(k), 4'hF, 1'b1, 32'hB0 + 32'(k));
      chk($sformatf("pushpop%0d outstanding", k), 64'(outstanding), 8);
    end
    chk("pushpop no overflow", 64'(overflow), 0);
    chk("pushpop no error", 64'(err_count), 0);
    step(1'b1, 20'h1FF, 32'hBAD, 4'hF, 1'b0, '0);
    chk("overflow set", {overflow, 4'(outstanding)}, {1'b1, 4'd8});
    for (int k = 0; k < 8; k++) step(1'b0, '0, '0, '0, 1'b1, 32'hB8 + 32'(k));
    chk("drain counts", {32'(cmp_count), 32'(err_count)}, {32'd16, 32'd0});
    chk("drain empty", {empty, full, underflow}, 3'b100);
    do_reset();
    step(1'b1, 20'h7, 32'h77, 4'hF, 1'b1, 32'h0);
    chk("underflow set", 64'(underflow), 1);
    chk("underflow cmp_count", 64'(cmp_count), 0);
    chk("underflow outstanding", 64'(outstanding), 1);
    step(1'b0, '0, '0, '0, 1'b1, 32'h77);
    chk("underflow pushed entry", {32'(cmp_count), 16'(err_count), 16'(outstanding)}, {32'd1, 16'd0, 16'd0});
    do_reset();
    step(1'b1, 20'h9, 32'h99, 4'hF, 1'b0, '0);
    idle(40);
    chk("timeout early", 64'(timeout), 0);
    idle(30);
    chk("timeout set", 64'(timeout), 1);
    step(1'b1, 20'hA, 32'hAA, 4'hF, 1'b0, '0);
    step(1'b1, 20'hB, 32'hBB, 4'hF, 1'b0, '0);
    chk("pre-reset outstanding", 64'(outstanding), 3);
    do_reset();
    #1;
    chk_clear("midreset");
    step(1'b0, '0, '0, '0, 1'b1, 32'h0);
    chk("midreset queue discarded", {underflow, 16'(cmp_count)}, {1'b1, 16'd0});
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
